// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-requester RAM port arbiter.
// Requester indices, default bus widths and the round-robin pick rule.
package ram_arb_pkg;

  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 5;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_idx_e;

  // Winner among the requests; on contention the side that did not win last time.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input req_idx_e last);
    if (req == 2'b11) return (last == REQ_M1) ? 2'b01 : 2'b10;
    return req;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last winner.
// The en input suppresses the grant without disturbing the round-robin history.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output req_idx_e   last
);

  assign grant = en ? rr_pick(req, last) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_M1;
    end else if (|grant) begin
      last <= grant[1] ? REQ_M1 : REQ_M0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port and one registered read port of a dual-port RAM between
// requesters m0 and m1, with independent round-robin and read-after-write protection.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_wr_valid,
  output logic               m0_wr_ready,
  input  logic [A_WIDTH-1:0] m0_wr_addr,
  input  logic [D_WIDTH-1:0] m0_wr_data,
  input  logic               m0_rd_valid,
  output logic               m0_rd_ready,
  input  logic [A_WIDTH-1:0] m0_rd_addr,
  output logic               m0_rsp_valid,
  output logic [D_WIDTH-1:0] m0_rsp_data,
  input  logic               m1_wr_valid,
  output logic               m1_wr_ready,
  input  logic [A_WIDTH-1:0] m1_wr_addr,
  input  logic [D_WIDTH-1:0] m1_wr_data,
  input  logic               m1_rd_valid,
  output logic               m1_rd_ready,
  input  logic [A_WIDTH-1:0] m1_rd_addr,
  output logic               m1_rsp_valid,
  output logic [D_WIDTH-1:0] m1_rsp_data,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  logic [1:0]         wr_req, wr_pick, wr_grant;
  logic [1:0]         rd_req, rd_pick, rd_grant;
  req_idx_e           wr_last, rd_last;
  logic               rd_wait, hazard;
  logic [A_WIDTH-1:0] rd_pick_addr;
  logic [1:0]         rsp_vld_p1;

  assign wr_req = {m1_wr_valid, m0_wr_valid};
  assign rd_req = {m1_rd_valid, m0_rd_valid};

  // Grants are held off while reset is asserted so nothing reaches the RAM.
  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .en    (rst_n && !rd_wait),
    .grant (wr_grant),
    .last  (wr_last)
  );

  assign wr_pick           = rr_pick(wr_req, wr_last);
  assign ram_write_enable  = |wr_grant;
  assign ram_address_write = !ram_write_enable ? '0 : (wr_pick[1] ? m1_wr_addr : m0_wr_addr);
  assign ram_data_write    = !ram_write_enable ? '0 : (wr_pick[1] ? m1_wr_data : m0_wr_data);

  // A read colliding with this cycle's write would return stale data; hold it back.
  assign rd_pick      = rr_pick(rd_req, rd_last);
  assign rd_pick_addr = rd_pick[1] ? m1_rd_addr : m0_rd_addr;
  assign hazard       = (|rd_pick) && ram_write_enable && (rd_pick_addr == ram_address_write);

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .en    (rst_n && !hazard),
    .grant (rd_grant),
    .last  (rd_last)
  );

  assign ram_address_read = (|rd_grant) ? rd_pick_addr : '0;

  assign m0_wr_ready = wr_grant[0];
  assign m1_wr_ready = wr_grant[1];
  assign m0_rd_ready = rd_grant[0];
  assign m1_rd_ready = rd_grant[1];

  // p0 -> p1: read grant travels with the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 2'b00;
      rd_wait    <= 1'b0;
    end else begin
      rsp_vld_p1 <= rd_grant;
      rd_wait    <= hazard;
    end
  end

  assign m0_rsp_valid = rsp_vld_p1[0];
  assign m1_rsp_valid = rsp_vld_p1[1];
  assign m0_rsp_data  = rsp_vld_p1[0] ? ram_data_read : '0;
  assign m1_rsp_data  = rsp_vld_p1[1] ? ram_data_read : '0;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one dual-port RAM between two requesters, m0 and m1. The RAM has one write port and one registered read port.
- Round-robin arbitration runs independently for writes and for reads.
- Read responses are routed back to the requester that issued the read.
- A same-cycle read/write to the same address stalls the read, so the requester always gets read-after-write data.
- Single clock domain; the RAM's clk_write and clk_read are both tied to clk at integration.

Parameters:
D_WIDTH, 16, data width of RAM word and requester data buses
A_WIDTH, 5, address width (RAM depth 2**A_WIDTH)

Ports:
clk  in  1  clock for arbiter and RAM
rst_n  in  1  asynchronous, active-low reset
mX_wr_valid  in  1  write request (X = 0,1; one set per requester)
mX_wr_ready  out  1  write accepted this cycle
mX_wr_addr  in  A_WIDTH  write address
mX_wr_data  in  D_WIDTH  write data
mX_rd_valid  in  1  read request
mX_rd_ready  out  1  read accepted this cycle
mX_rd_addr  in  A_WIDTH  read address
mX_rsp_valid  out  1  read data valid, one-cycle pulse
mX_rsp_data  out  D_WIDTH  read data
ram_write_enable  out  1  to RAM write_enable
ram_address_write  out  A_WIDTH  to RAM address_write
ram_data_write  out  D_WIDTH  to RAM data_write
ram_address_read  out  A_WIDTH  to RAM address_read
ram_data_read  in  D_WIDTH  from RAM data_read

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. Requesters hold valid, addr and data stable until accepted. The ready outputs are combinational from the valid inputs and the arbiter state.
- Write arbitration:
  - One valid requester: that requester is granted.
  - Both valid: grant goes to the requester that is not wr_last.
  - wr_last updates to the granted index on every write grant.
  - Reset value of wr_last is 1, so m0 wins the first contention.
- Read arbitration: identical scheme with an independent rd_last register (reset 1).
- At most one write grant and one read grant per cycle. A write and a read may be granted in the same cycle.
- RAM drive:
  - On a write grant: ram_write_enable=1; ram_address_write and ram_data_write come from the granted requester.
  - No write grant: ram_write_enable=0, address and data 0.
  - ram_address_read comes from the granted read requester, or 0 when there is no read grant.
- Read latency: a read granted in cycle N asserts mX_rsp_valid for exactly cycle N+1 to the same requester.
  - mX_rsp_data = ram_data_read, valid only while mX_rsp_valid is high.
  - Responses have no back-pressure.
  - A new read may be granted every cycle, giving back-to-back responses.
- Hazard:
  - If the read arbitration winner's address equals the granted write address in the same cycle, no read is granted that cycle. Both rd_ready are 0 and rd_last is unchanged.
  - The stall sets rd_wait=1.
- rd_wait:
  - While rd_wait=1, all wr_ready are forced to 0 and the read arbitrates normally; rd_wait clears the next cycle.
  - This bounds a hazard-stalled read to at most 2 cycles of delay.
  - With no hazard, rd_wait stays 0.
- Reset values: all ready and rsp_valid outputs 0, ram_write_enable 0, RAM address and data outputs 0, wr_last=1, rd_last=1, rd_wait=0.
- Reset mid-operation: an in-flight read response is dropped (rsp_valid cleared asynchronously). A write presented in the same cycle reset asserts is not performed. RAM contents are not cleared.
- Deassertion of valid without acceptance is a protocol violation; behaviour is undefined, and the bench asserts against it.

Decomposition:
- Package ram_arb_pkg: D_WIDTH and A_WIDTH defaults, requester-index typedef (REQ_M0=0, REQ_M1=1).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Ports: clk, rst_n, req[1:0], en, grant[1:0], last register.
  - Instantiated twice, once for write and once for read.
  - The read instance's en is gated by the hazard check.

Test Plan:
- Both wr_valid every cycle, m0 addr 3/data 16'h1111, m1 addr 4/data 16'h2222 -> grants alternate m0, m1, m0, starting with m0; ram_write_enable high every cycle.
- m0 writes addr 7 data 16'hBEEF, then m1 reads addr 7 two cycles later -> m1_rsp_valid exactly one cycle after m1_rd_ready, m1_rsp_data=16'hBEEF.
- Same cycle, m0 writes addr 9 data 16'hCAFE and m1 reads addr 9 (old 16'h0000) -> read stalled one cycle; write blocked the following cycle; read then returns 16'hCAFE.
- Continuous reads from both requesters, m0 addr 1 and m1 addr 2 -> one response per cycle, alternating m0/m1, each tagged correctly with no gaps.
- rst_n low one cycle after an m0 read grant -> m0_rsp_valid 0 immediately; all readies 0; after release, the first contended write goes to m0.
